present80_round_engine: RTL and testbench
=========================================

# present80_round_engine

Iterative PRESENT-80 encryption core. It sits directly downstream of the 80-bit key schedule logic and consumes the round keys that schedule produces. The block registers a 64-bit plaintext and an 80-bit master key. It then runs one cipher round per clock, updating the key register in lockstep, and returns the 64-bit ciphertext over a valid/ready stream interface.

## Interface
- `BLK_W`, 64, cipher state width
- `KEY_W`, 80, key register width
- `NUM_ROUNDS`, 31, number of full rounds; the final key whitening is applied after round `NUM_ROUNDS`
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  `pt`/`key_in` valid
- `in_ready`  out  1  engine can accept a block
- `pt`  in  64  plaintext
- `key_in`  in  80  master key; bit 79 is the MSB
- `out_valid`  out  1  `ct` valid
- `out_ready`  in  1  consumer accepts `ct`
- `ct`  out  64  ciphertext
- `busy`  out  1  rounds in progress

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: `state`<=`pt`, `key`<=`key_in`, `rc`<=1, go to RUN.
- **RUN**, one round per cycle, with `rc` in 1..31:
  - Round key: `rk` = `key[79:16]`.
  - `t` = pLayer(sBoxLayer(`state` ^ `rk`)).
  - Next key: rotate `key` left by 61. Then replace bits [79:76] with S([79:76]). Then XOR bits [19:15] with `rc[4:0]`.
  - If `rc`<31: `state`<=`t`, `key`<=next key, `rc`<=`rc`+1.
  - If `rc`==31: `state`<=`t` ^ nextkey[79:16] (this is K32 whitening), go to DONE.
- **DONE**
  - `out_valid`=1; `ct` mirrors `state`.
  - On `out_ready`: go to IDLE.
  - `ct`/`state` hold their value while `out_ready`=0.
- **S-box** (hex in -> out, 0..F): C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
- **pLayer**: bit i moves to bit (16·i) mod 63 for i in 0..62; bit 63 is fixed.
- **Widths**: `rc` is 5 bits. The counter XOR uses exactly 5 bits, so no carry reaches bit 20. `rc` never wraps, because the exit condition fires at 31.
- `in_ready` is asserted only in IDLE. Input is ignored in RUN and DONE, with no buffering.
- `out_valid`, `ct` and `busy` are registered or decoded from the state register; they have no combinational path from the inputs. `in_ready` is decoded from state only.

## Timing
- **Reset values**:
  - FSM = IDLE, so `in_ready`=1.
  - `out_valid`=0, `busy`=0, `ct`=0.
  - `state`, `key` and `rc` = 0.
- **Latency**: accept at edge N. Rounds complete on edges N+1..N+31. `out_valid`=1 from edge N+31.
- Sustained throughput is one block per 33 cycles when `out_ready` is tied high: 1 cycle accept, 31 cycles run, 1 cycle handshake.
- `busy`=1 exactly during the 31 RUN cycles.
- If `in_valid` and `out_ready` are high in the same cycle in DONE, only the output completes. The input is accepted in the next IDLE cycle.
- `rst` asserted mid-RUN or in DONE: everything returns to reset values immediately and the block in flight is discarded. No output is produced for it.
- `pt`/`key_in` are sampled only on the accept edge. Changing them afterwards has no effect.

## Structure
- Shared package `present_pkg`:
  - constants `BLK_W`, `KEY_W`, `NUM_ROUNDS`
  - S-box table constant
  - pure functions `p_layer(64b)` and `key_step(80b key, 5b rc)`
  - FSM enum `present_st_t` {IDLE, RUN, DONE}
- Sub-module `present_sbox4`: a 4-bit combinational S-box. It is instantiated 16× for the state layer and 1× for the key nibble.

## Test plan
- `pt`=0000000000000000, `key_in`=00000000000000000000 -> `ct`=5579C1387B228445; `out_valid` rises exactly 31 cycles after the accept.
- `pt`=0, `key_in`=FFFFFFFFFFFFFFFFFFFF -> `ct`=E72C46C0F5945049.
- `pt`=FFFFFFFFFFFFFFFF, `key_in`=0 -> `ct`=A112FFC72F68417B. Then hold `out_ready`=0 for 10 cycles: `ct` stable, `in_ready`=0 throughout.
- `pt`=FFFFFFFFFFFFFFFF, `key_in`=FFFFFFFFFFFFFFFFFFFF, with a second `in_valid` pulse driven during RUN -> `ct`=3333DCD3213210D2; the second input is not accepted.
- Assert `rst` on cycle 12 of RUN -> `out_valid`=0, `busy`=0, `in_ready`=1 immediately. A fresh all-zero block then returns 5579C1387B228445.
- Back-to-back vectors 1 and 2 with `in_valid`/`out_ready` held high -> both ciphertexts correct, in order; second accept occurs 33 cycles after the first.

Source files
------------

// File: rtl/present80_round_engine_pkg.sv
// Shared constants, S-box table, linear helper functions and FSM encoding
// for the iterative PRESENT-80 round engine.
package present_pkg;

    localparam int BLK_W      = 64;
    localparam int KEY_W      = 80;
    localparam int NUM_ROUNDS = 31;

    // Nibble i of the table holds S(i); S(0)=C ... S(F)=2.
    localparam logic [63:0] SBOX_TBL = 64'h21748FE3DA09B65C;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } present_st_t;

    // Bit i moves to (16*i) mod 63; bit 63 stays put.
    function automatic logic [BLK_W-1:0] p_layer(input logic [BLK_W-1:0] d);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int i = 0; i < 63; i++) begin
            o[(16 * i) % 63] = d[i];
        end
        o[63] = d[63];
        return o;
    endfunction

    // Rotate left by 61 and fold in the round counter. The S-box on the top
    // nibble commutes with the counter XOR (disjoint bits), so the caller
    // substitutes bits [79:76] of this result afterwards.
    function automatic logic [KEY_W-1:0] key_step(input logic [KEY_W-1:0] k,
                                                  input logic [4:0]       rc);
        logic [KEY_W-1:0] r;
        r = {k[18:0], k[79:19]};
        r[19:15] = r[19:15] ^ rc;
        return r;
    endfunction

endpackage

// File: rtl/present80_round_engine_if.sv
// Valid/ready input and output streams of the PRESENT-80 round engine.
interface present80_round_engine_if;
    import present_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] pt;
    logic [KEY_W-1:0] key_in;
    logic             out_valid;
    logic             out_ready;
    logic [BLK_W-1:0] ct;
    logic             busy;

    modport slave (
        input  in_valid, pt, key_in, out_ready,
        output in_ready, out_valid, ct, busy
    );

    modport master (
        output in_valid, pt, key_in, out_ready,
        input  in_ready, out_valid, ct, busy
    );

endinterface

// File: rtl/present80_round_engine_sbox4.sv
// 4-bit PRESENT S-box, purely combinational table lookup.
module present_sbox4
    import present_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = SBOX_TBL[{i_nib, 2'b00} +: 4];

endmodule

// File: rtl/present80_round_engine.sv
// Iterative PRESENT-80 encryption: one round per clock, key schedule updated
// in lockstep, final K32 whitening folded into the last round.
module present80_round_engine
    import present_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    present80_round_engine_if.slave   bus
);

    present_st_t      r_fsm;
    present_st_t      w_fsm_nxt;
    logic [BLK_W-1:0] r_state;
    logic [KEY_W-1:0] r_key;
    logic [4:0]       r_rc;

    logic             w_accept;
    logic             w_last;
    logic [BLK_W-1:0] w_x;
    logic [BLK_W-1:0] w_sb;
    logic [BLK_W-1:0] w_t;
    logic [KEY_W-1:0] w_key_lin;
    logic [3:0]       w_key_nib;
    logic [KEY_W-1:0] w_key_nxt;

    assign w_accept = (r_fsm == IDLE) && bus.in_valid;
    assign w_last   = (r_rc == 5'(NUM_ROUNDS));

    // Round datapath: add round key, 16 parallel S-boxes, bit permutation.
    assign w_x = r_state ^ r_key[79:16];

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        present_sbox4 u_sbox (
            .i_nib (w_x[4*g +: 4]),
            .o_nib (w_sb[4*g +: 4])
        );
    end

    assign w_t = p_layer(w_sb);

    assign w_key_lin = key_step(r_key, r_rc);

    present_sbox4 u_key_sbox (
        .i_nib (w_key_lin[79:76]),
        .o_nib (w_key_nib)
    );

    assign w_key_nxt = {w_key_nib, w_key_lin[75:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            IDLE:    if (bus.in_valid)  w_fsm_nxt = RUN;
            RUN:     if (w_last)        w_fsm_nxt = DONE;
            DONE:    if (bus.out_ready) w_fsm_nxt = IDLE;
            default:                    w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
            r_key   <= '0;
            r_rc    <= '0;
        end else if (w_accept) begin
            r_state <= bus.pt;
            r_key   <= bus.key_in;
            r_rc    <= 5'd1;
        end else if (r_fsm == RUN) begin
            if (w_last) begin
                r_state <= w_t ^ w_key_nxt[79:16];
            end else begin
                r_state <= w_t;
                r_key   <= w_key_nxt;
                r_rc    <= r_rc + 5'd1;
            end
        end
    end

    assign bus.in_ready  = (r_fsm == IDLE);
    assign bus.out_valid = (r_fsm == DONE);
    assign bus.busy      = (r_fsm == RUN);
    assign bus.ct        = r_state;

endmodule

// File: tb/tb_present80_round_engine.sv
// Directed-vector bench for present80_round_engine using published PRESENT-80 vectors.
module tb_present80_round_engine;

    logic clk;
    logic rst;

    int checks;
    int failures;

    present80_round_engine_if u_if ();

    present80_round_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] PT0  = 64'h0000000000000000;
    localparam logic [63:0] PT1  = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [79:0] K0   = 80'h00000000000000000000;
    localparam logic [79:0] K1   = 80'hFFFFFFFFFFFFFFFFFFFF;
    localparam logic [63:0] CT00 = 64'h5579C1387B228445;
    localparam logic [63:0] CT01 = 64'hE72C46C0F5945049;
    localparam logic [63:0] CT10 = 64'hA112FFC72F68417B;
    localparam logic [63:0] CT11 = 64'h3333DCD3213210D2;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept a block, wait (bounded) for out_valid, return latency and ciphertext.
    // Optionally pulses in_valid with a different block while the engine runs.
    task automatic run_block(input logic [63:0] pt, input logic [79:0] key,
                             input bit glitch_in, output int lat, output logic [63:0] ct);
        int cyc;
        @(negedge clk);
        u_if.pt       = pt;
        u_if.key_in   = key;
        u_if.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        u_if.pt       = ~pt;
        u_if.key_in   = ~key;
        check("busy_after_accept", 80'(u_if.busy), 80'd1);
        cyc = 0;
        while (!u_if.out_valid && cyc < 40) begin
            if (glitch_in && (cyc == 5 || cyc == 6)) begin
                u_if.in_valid = 1'b1;
                u_if.pt       = PT0;
                u_if.key_in   = K0;
            end else begin
                u_if.in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (glitch_in && cyc == 6) check("in_ready_run", 80'(u_if.in_ready), 80'd0);
        end
        u_if.in_valid = 1'b0;
        lat = cyc;
        ct  = u_if.ct;
    endtask

    task automatic handshake_out();
        u_if.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [63:0] ct;
        int          acc[2];
        logic [63:0] outs[2];
        int          n_acc;
        int          n_out;
        int          cyc;

        checks         = 0;
        failures       = 0;
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b0;
        u_if.pt        = '0;
        u_if.key_in    = '0;
        rst            = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_in_ready",  80'(u_if.in_ready),  80'd1);
        check("rst_out_valid", 80'(u_if.out_valid), 80'd0);
        check("rst_busy",      80'(u_if.busy),      80'd0);
        check("rst_ct",        80'(u_if.ct),        80'd0);

        // Vector 1: latency and ciphertext.
        run_block(PT0, K0, 1'b0, lat, ct);
        check("v1_latency", 80'(lat), 80'd31);
        check("v1_ct", 80'(ct), 80'(CT00));
        check("v1_busy_done", 80'(u_if.busy), 80'd0);
        handshake_out();
        check("v1_back_idle", 80'(u_if.in_ready), 80'd1);
        check("v1_ov_drop", 80'(u_if.out_valid), 80'd0);

        // Vector 2.
        run_block(PT0, K1, 1'b0, lat, ct);
        check("v2_ct", 80'(ct), 80'(CT01));
        handshake_out();

        // Vector 3 with output back-pressure.
        run_block(PT1, K0, 1'b0, lat, ct);
        check("v3_ct", 80'(ct), 80'(CT10));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("v3_hold_ct", 80'(u_if.ct), 80'(CT10));
            check("v3_hold_in_ready", 80'(u_if.in_ready), 80'd0);
            check("v3_hold_ov", 80'(u_if.out_valid), 80'd1);
        end
        handshake_out();

        // Vector 4 with an in_valid pulse during RUN that must be ignored.
        run_block(PT1, K1, 1'b1, lat, ct);
        check("v4_latency", 80'(lat), 80'd31);
        check("v4_ct", 80'(ct), 80'(CT11));
        handshake_out();
        repeat (3) @(negedge clk);
        check("v4_no_second_accept", 80'(u_if.busy), 80'd0);
        check("v4_idle", 80'(u_if.in_ready), 80'd1);

        // Reset on cycle 12 of RUN.
        @(negedge clk);
        u_if.pt       = PT1;
        u_if.key_in   = K1;
        u_if.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        repeat (11) @(negedge clk);
        check("pre_rst_busy", 80'(u_if.busy), 80'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_ov",   80'(u_if.out_valid), 80'd0);
        check("mid_rst_busy", 80'(u_if.busy),      80'd0);
        check("mid_rst_ir",   80'(u_if.in_ready),  80'd1);
        check("mid_rst_ct",   80'(u_if.ct),        80'd0);
        @(negedge clk);
        rst = 1'b0;
        run_block(PT0, K0, 1'b0, lat, ct);
        check("post_rst_latency", 80'(lat), 80'd31);
        check("post_rst_ct", 80'(ct), 80'(CT00));
        handshake_out();

        // Back-to-back with in_valid and out_ready held high.
        @(negedge clk);
        u_if.pt        = PT0;
        u_if.key_in    = K0;
        u_if.in_valid  = 1'b1;
        u_if.out_ready = 1'b1;
        n_acc = 0;
        n_out = 0;
        cyc   = 0;
        while (n_out < 2 && cyc < 120) begin
            if (n_acc == 1) begin
                u_if.pt     = PT0;
                u_if.key_in = K1;
            end
            if (n_acc == 2) u_if.in_valid = 1'b0;
            if (u_if.in_ready && u_if.in_valid && n_acc < 2) begin
                acc[n_acc] = cyc;
                n_acc++;
            end
            if (u_if.out_valid) begin
                outs[n_out] = u_if.ct;
                n_out++;
            end
            @(negedge clk);
            cyc++;
        end
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b0;
        check("b2b_outputs", 80'(n_out), 80'd2);
        check("b2b_accepts", 80'(n_acc), 80'd2);
        if (n_out == 2 && n_acc == 2) begin
            check("b2b_ct0", 80'(outs[0]), 80'(CT00));
            check("b2b_ct1", 80'(outs[1]), 80'(CT01));
            check("b2b_spacing", 80'(acc[1] - acc[0]), 80'd33);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
